// File: rtl/dvs_event_fifo_pkg.sv
// Shared definitions for the DVS event path: widths, depth and the event word layout.
package pkg_dvs;

  localparam int DVS_DATA_WIDTH = 32;
  localparam int DVS_FIFO_DEPTH = 1024;
  localparam int FIFO_AWIDTH    = $clog2(DVS_FIFO_DEPTH) + 1;
  localparam int DROP_CNT_WIDTH = 16;

  // Address-event word as produced by the pixel array readout.
  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        polarity;
    logic [10:0] timestamp;
  } dvs_event_t;

endpackage

// File: rtl/dvs_event_fifo_mem.sv
// 1W1R storage for the event FIFO. Synchronous read with a registered output
// port; the behavioural array can be swapped for an SRAM macro.
module fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_W-1:0]     i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_rd_en,
  input  logic [ADDR_W-1:0]     i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_rd_data;

  // Write port.
  // NOTE: the array is deliberately not reset, so it can map onto an SRAM; only the read register below is.
  always_ff @(posedge clk) begin
    if (i_wr_en) r_mem[i_wr_addr] <= i_wr_data;
  end

  // Registered read port; holds the last popped word until the next pop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_rd_data <= '0;
    else if (i_rd_en) r_rd_data <= r_mem[i_rd_addr];
  end

  assign o_rd_data = r_rd_data;

endmodule

// File: rtl/dvs_event_fifo.sv
// Event buffer between the pixel-array readout and the SPI read path.
// Pointers carry a wrap bit in the MSB; occupancy is their modular difference.
module dvs_event_fifo
  import pkg_dvs::*;
#(
  parameter int DATA_WIDTH = DVS_DATA_WIDTH,
  parameter int DEPTH      = DVS_FIFO_DEPTH,
  parameter int AWIDTH     = $clog2(DEPTH) + 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      fifo_rst_n,
  input  logic                      wr_valid,
  input  logic [DATA_WIDTH-1:0]     wr_data,
  output logic                      wr_ready,
  input  logic                      fifo_rd_en,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      rd_data_valid,
  input  logic [AWIDTH-1:0]         irq_assert_thresh,
  input  logic [AWIDTH-1:0]         irq_deassert_thresh,
  output logic [AWIDTH-1:0]         fifo_numel,
  output logic                      irq,
  output logic                      overflow,
  output logic                      underflow,
  output logic [DROP_CNT_WIDTH-1:0] drop_cnt
);

  localparam int MEM_AW = AWIDTH - 1;

  logic [AWIDTH-1:0]         r_wr_ptr;
  logic [AWIDTH-1:0]         r_rd_ptr;
  logic                      r_irq;
  logic                      r_overflow;
  logic                      r_underflow;
  logic                      r_rd_valid;
  logic [DROP_CNT_WIDTH-1:0] r_drop_cnt;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic              w_pop;
  logic              w_drop;
  logic              w_empty_pop;
  logic [AWIDTH-1:0] w_wr_ptr_nxt;
  logic [AWIDTH-1:0] w_rd_ptr_nxt;
  logic [AWIDTH-1:0] w_numel_nxt;
  logic              w_irq_nxt;

  // Full/empty come from registered pointers only, so a same-cycle pop
  // never makes room for a write to a full FIFO.
  assign w_full  = (r_wr_ptr[AWIDTH-1] != r_rd_ptr[AWIDTH-1]) &&
                   (r_wr_ptr[MEM_AW-1:0] == r_rd_ptr[MEM_AW-1:0]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

  assign w_push      = wr_valid   && !w_full;
  assign w_drop      = wr_valid   &&  w_full;
  assign w_pop       = fifo_rd_en && !w_empty;
  assign w_empty_pop = fifo_rd_en &&  w_empty;

  assign w_wr_ptr_nxt = w_push ? r_wr_ptr + AWIDTH'(1) : r_wr_ptr;
  assign w_rd_ptr_nxt = w_pop  ? r_rd_ptr + AWIDTH'(1) : r_rd_ptr;
  assign w_numel_nxt  = w_wr_ptr_nxt - w_rd_ptr_nxt;

  // Hysteretic irq on the next-state occupancy; the set rule wins over the clear rule.
  // NOTE: the default assignment first keeps this always_comb free of inferred latches.
  always_comb begin
    w_irq_nxt = r_irq;
    if (irq_assert_thresh == '0)               w_irq_nxt = 1'b0;
    else if (w_numel_nxt >= irq_assert_thresh)  w_irq_nxt = 1'b1;
    else if (w_numel_nxt <= irq_deassert_thresh) w_irq_nxt = 1'b0;
  end

  // Pointer, flag and counter state; soft clear overrides any traffic in the same cycle.
  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_irq       <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_drop_cnt  <= '0;
    end else if (!fifo_rst_n) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_irq       <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_drop_cnt  <= '0;
    end else begin
      r_wr_ptr   <= w_wr_ptr_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_irq      <= w_irq_nxt;
      r_rd_valid <= w_pop;
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + DROP_CNT_WIDTH'(1);
      end
      if (w_empty_pop) r_underflow <= 1'b1;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_W     (MEM_AW)
  ) u_mem (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_push && fifo_rst_n),
    .i_wr_addr (r_wr_ptr[MEM_AW-1:0]),
    .i_wr_data (wr_data),
    .i_rd_en   (w_pop && fifo_rst_n),
    .i_rd_addr (r_rd_ptr[MEM_AW-1:0]),
    .o_rd_data (rd_data)
  );

  assign wr_ready      = !w_full;
  assign fifo_numel    = r_wr_ptr - r_rd_ptr;
  assign irq           = r_irq;
  assign overflow      = r_overflow;
  assign underflow     = r_underflow;
  assign drop_cnt      = r_drop_cnt;
  assign rd_data_valid = r_rd_valid;

endmodule
